// File: rtl/bsn_result_streamer.sv
// Captures the bitonic sorter's parallel output a fixed latency after start
// and replays it one word per valid/ready transfer, slot 0 first.
module bsn_result_streamer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_INPUTS   = 8,
  parameter  int LATENCY    = 6,
  localparam int IW         = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DATA_WIDTH*N_INPUTS-1:0] sort_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [IW-1:0]                  m_index,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t                                 state_q, state_d;
  logic [CW-1:0]                          cnt_q, cnt_d;
  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]    shadow_q, shadow_d;
  logic [IW-1:0]                          idx_q, idx_d;
  logic                                   done_q, done_d;
  logic                                   ovr_q, ovr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        ovr_d = start;
        // sort_data is only trusted on the edge the counter expires
        if (cnt_q == '0) begin
          shadow_d = sort_data;
          idx_d    = '0;
          state_d  = STREAM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STREAM: begin
        ovr_d = start;
        if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid = (state_q == STREAM);
  assign m_data  = shadow_q[idx_q];
  assign m_index = idx_q;
  assign m_last  = m_valid && (idx_q == LAST_IDX);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;

endmodule
